vgahdmi_linefetch: RTL
======================

Name: vgahdmi_linefetch

Overview:
Upstream feeder for the 640x480 bitmap display stage. It answers that stage's byte-read port (13-bit dispAddr, 8-bit dispData), which scans a 256-line x 32-byte 1bpp bitmap. Data is served from an internal double line buffer (2 x 32 bytes). The other bank is prefetched from main memory over a 32-bit word-read req/ack bus. It runs in the pixel clock domain.

Parameters:
C_addr_bits, 30, width of bus word address and base_addr.
C_reset_fetch, 1, 1 = after reset, fetch line 0 into bank 0 and then line 1 into bank 1; 0 = start in IDLE with banks undefined.

Ports:
clk  in  1  pixel clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
base_addr  in  C_addr_bits  word address of bitmap line 0; sampled only when a fetch of line 0 starts.
disp_addr  in  13  byte address from the display: [12:5] line, [4:0] byte within line.
disp_data  out  8  byte at disp_addr; registered, 1-cycle latency.
bus_addr  out  C_addr_bits  word address of the current request.
bus_req  out  1  read request; held with stable bus_addr until bus_ack.
bus_ack  in  1  read acknowledge; bus_data is valid in the same cycle.
bus_data  in  32  read data, little-endian: byte k = bus_data[8k+7:8k].
underrun  out  1  1-cycle pulse: a line change arrived while a fetch was still in progress.

Behaviour:
- Reset (async): disp_data=0, bus_req=0, bus_addr=0, underrun=0, FSM=IDLE, word counter=0, pending=0, prev_line=0. Buffer contents are not cleared.
- Read path: every cycle, disp_data <= buf[disp_addr[5]][disp_addr[4:0]]. Bank = line[0].
- Line event: prev_line <= disp_addr[12:5] every cycle. An event fires when disp_addr[12:5] != prev_line, with new line N.
- On event, target line T = (N+1) mod 256, written to bank T[0]. The 255->0 wrap needs no special case: line 0 is prefetched when line 255 begins.
- Fetch of line T: 8 word reads. Word address = lbase + T*8 + w, for w = 0..7.
  - lbase = base_addr captured at the start of any fetch with T=0; otherwise the held value.
  - Arithmetic is modulo 2^C_addr_bits.
  - Word w, byte k goes to buf[T[0]][4w+k].
- FSM:
  - IDLE: on event or pending -> REQ with w=0.
  - REQ: bus_req=1. On bus_ack, write the word. If w<7: w++ and stay in REQ; bus_req stays high and bus_addr advances the next cycle, giving 1 word/cycle if acked continuously. If w=7: -> IDLE.
  - After reset with C_reset_fetch=1: REQ for T=0 (bank 0), then T=1 (bank 1), then IDLE. Events during this init sequence are handled by the pending rule below.
- Event while in REQ:
  - Set pending=1 with T=N+1; a later event overwrites it.
  - Pulse underrun, except during the post-reset init sequence.
  - The running fetch completes all 8 words and is never aborted.
  - The pending fetch then starts in the cycle after the final ack (IDLE for 1 cycle).
- Boundaries:
  - Event in the same cycle as the final (w=7) ack: no underrun; the new fetch starts the next cycle.
  - A display held at disp_addr=0 (vblank) generates no events, so the bus stays idle.
  - Reset mid-fetch drops bus_req immediately and asynchronously; the bus slave must tolerate an abandoned request.
- The buffer is written only on bus_ack cycles. A read and a write to the same byte in one cycle returns the old byte.

Test Plan:
- Reset with C_reset_fetch=1, base_addr=0x1000, slave acks every cycle -> bus_addr 0x1000..0x100F in order (lines 0 and 1), bus_req low after 16 acks, underrun never pulses.
- After init, step disp_addr[12:5] 0->1 -> one fetch of words 0x1010..0x1017 into bank 0. Then sweep disp_addr 0x20..0x3F -> disp_data returns the bytes of line 1, 1 cycle later, little-endian (word 0x44332211 reads back 0x11,0x22,0x33,0x44).
- Line event 254->255 -> fetch of line 0 with newly sampled base_addr=0x2000; addresses 0x2000..0x2007 into bank 0.
- Slave acks every 4th cycle, line events every 20 cycles -> underrun pulses once per late event; pending fetch starts exactly 1 cycle after the final ack.
- Event asserted in the same cycle as the 8th ack -> no underrun; next bus_req rises 1 cycle later with w=0.
- Assert reset while bus_req=1 at w=3 -> bus_req, disp_data, underrun go 0 asynchronously; after release, the init sequence restarts at word lbase+0.

Source files
------------

// File: rtl/vgahdmi_linefetch.sv
// Line prefetcher for the 640x480 1bpp bitmap stage: serves display byte reads from
// a 2 x 32-byte line buffer while the other bank is filled over a 32-bit word bus.
module vgahdmi_linefetch #(
    parameter int C_addr_bits   = 30,
    parameter bit C_reset_fetch = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [C_addr_bits-1:0] base_addr,
    input  logic [12:0]            disp_addr,
    output logic [7:0]             disp_data,
    output logic [C_addr_bits-1:0] bus_addr,
    output logic                   bus_req,
    input  logic                   bus_ack,
    input  logic [31:0]            bus_data,
    output logic                   underrun
);

    // state | meaning
    // IDLE  | no fetch running; starts init, event or pending fetch
    // REQ   | bus_req high, word w of line tline outstanding

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [1:0] INIT_NONE  = 2'd0;
    localparam logic [1:0] INIT_L0    = 2'd1;
    localparam logic [1:0] INIT_L1    = 2'd2;
    localparam logic [1:0] INIT_RUN1  = 2'd3;
    localparam logic [1:0] INIT_START = C_reset_fetch ? INIT_L0 : INIT_NONE;

    state_t                 state, state_nx;
    logic [2:0]             w, w_nx;
    logic [7:0]             tline, tline_nx;
    logic [C_addr_bits-1:0] lbase, lbase_nx;
    logic [1:0]             init_stage, init_nx;
    logic                   pending, pending_nx;
    logic [7:0]             pend_line, pend_line_nx;
    logic                   underrun_nx;
    logic [7:0]             prev_line;
    logic [7:0]             cur_line;
    logic [7:0]             next_line;
    logic                   line_event;
    logic                   last_ack;
    logic [7:0]             line_buf [64];

    assign cur_line   = disp_addr[12:5];
    assign next_line  = cur_line + 8'd1;
    assign line_event = (cur_line != prev_line);
    assign last_ack   = (state == REQ) && bus_ack && (w == 3'd7);

    assign bus_req  = (state == REQ);
    assign bus_addr = lbase + C_addr_bits'({tline, w});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            w          <= 3'd0;
            tline      <= 8'd0;
            lbase      <= '0;
            init_stage <= INIT_START;
            pending    <= 1'b0;
            pend_line  <= 8'd0;
            prev_line  <= 8'd0;
            underrun   <= 1'b0;
            disp_data  <= 8'd0;
        end else begin
            state      <= state_nx;
            w          <= w_nx;
            tline      <= tline_nx;
            lbase      <= lbase_nx;
            init_stage <= init_nx;
            pending    <= pending_nx;
            pend_line  <= pend_line_nx;
            prev_line  <= cur_line;
            underrun   <= underrun_nx;
            disp_data  <= line_buf[disp_addr[5:0]];
        end
    end

    // Buffer is not reset; a read and write of the same byte in one cycle returns old data.
    always_ff @(posedge clk) begin
        if (state == REQ && bus_ack) begin
            for (int k = 0; k < 4; k++) begin
                line_buf[{tline[0], w, 2'(k)}] <= bus_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_nx     = state;
        w_nx         = w;
        tline_nx     = tline;
        lbase_nx     = lbase;
        init_nx      = init_stage;
        pending_nx   = pending;
        pend_line_nx = pend_line;
        underrun_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (init_stage == INIT_L0) begin
                    state_nx = REQ;
                    w_nx     = 3'd0;
                    tline_nx = 8'd0;
                    lbase_nx = base_addr;
                    init_nx  = INIT_L1;
                end else if (init_stage == INIT_L1) begin
                    state_nx = REQ;
                    w_nx     = 3'd0;
                    tline_nx = 8'd1;
                    init_nx  = INIT_RUN1;
                end else if (line_event || pending) begin
                    state_nx   = REQ;
                    w_nx       = 3'd0;
                    tline_nx   = line_event ? next_line : pend_line;
                    pending_nx = 1'b0;
                    if (tline_nx == 8'd0) lbase_nx = base_addr;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    if (w == 3'd7) begin
                        state_nx = IDLE;
                        if (init_stage == INIT_RUN1) init_nx = INIT_NONE;
                    end else begin
                        w_nx = w + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A line change that cannot start immediately is queued; only the latest survives.
        if (line_event && !(state == IDLE && init_stage == INIT_NONE)) begin
            pending_nx   = 1'b1;
            pend_line_nx = next_line;
            underrun_nx  = (state == REQ) && !last_ack && (init_stage == INIT_NONE);
        end
    end

endmodule
